// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Multiplexed multi-digit 7-segment display driver. A load strobe captures a
// DIGITS-nibble hex value plus per-digit decimal points into a shadow
// register. The shadow is committed to the display register only at a frame
// boundary, so a frame is never torn. Each digit is held for DIV cycles. The
// first GUARD cycles of every dwell keep all anodes off to avoid ghosting.
// Leading zeros can optionally be blanked.
//
// Ports:
//   clk      in   clock
//   rst      in   asynchronous, active-high reset
//   load     in   single-cycle strobe; captures value and dp
//   value    in   [4*DIGITS-1:0] hex digits, nibble i is digit i (digit 0 = LSD)
//   dp       in   [DIGITS-1:0] decimal point per digit
//   seg      out  [7:0] bits 6:0 = segments g..a, bit 7 = dp (registered)
//   an       out  [DIGITS-1:0] one-hot digit enable (registered)
//   pending  out  a loaded value is waiting for the frame boundary
module seg7_scan_driver #(
  parameter int DIGITS     = 4,
  parameter int DIV        = 1000,
  parameter int GUARD      = 2,
  parameter int ACTIVE_LOW = 0,
  parameter int BLANK_LEAD = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an,
  output logic                  pending
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  // Idle pattern of the pins; XOR-ing with it also applies the polarity.
  localparam logic [7:0]        SEG_OFF  = (ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF   = (ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  function automatic logic [6:0] decode7(input logic [3:0] n);
    case (n)
      4'h0: decode7 = 7'h3F;
      4'h1: decode7 = 7'h06;
      4'h2: decode7 = 7'h5B;
      4'h3: decode7 = 7'h4F;
      4'h4: decode7 = 7'h66;
      4'h5: decode7 = 7'h6D;
      4'h6: decode7 = 7'h7D;
      4'h7: decode7 = 7'h07;
      4'h8: decode7 = 7'h7F;
      4'h9: decode7 = 7'h6F;
      4'hA: decode7 = 7'h77;
      4'hB: decode7 = 7'h7C;
      4'hC: decode7 = 7'h39;
      4'hD: decode7 = 7'h5E;
      4'hE: decode7 = 7'h79;
      default: decode7 = 7'h71;
    endcase
  endfunction

  logic [CNT_W-1:0]    div_cnt;
  logic [IDX_W-1:0]    idx;
  logic [4*DIGITS-1:0] shadow_val;
  logic [DIGITS-1:0]   shadow_dp;
  logic [4*DIGITS-1:0] disp_val;
  logic [DIGITS-1:0]   disp_dp;
  logic                tick;
  logic                frame_end;
  logic                guard_ok;

  assign tick      = (div_cnt == CNT_LAST);
  assign frame_end = tick && (idx == IDX_LAST);

  if (GUARD == 0) begin : g_no_guard
    assign guard_ok = 1'b1;
  end else begin : g_guard
    assign guard_ok = (div_cnt >= CNT_W'(GUARD));
  end

  // ---- p0: dwell counter and digit index ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      idx     <= '0;
    end else if (tick) begin
      div_cnt <= '0;
      idx     <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // ---- p0: shadow / display registers ----
  // A load landing exactly on frame_end bypasses the shadow so the new value
  // shows in the very next frame and nothing is left pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_val <= '0;
      shadow_dp  <= '0;
      disp_val   <= '0;
      disp_dp    <= '0;
      pending    <= 1'b0;
    end else begin
      if (load) begin
        shadow_val <= value;
        shadow_dp  <= dp;
      end
      if (frame_end) begin
        pending <= 1'b0;
        if (load) begin
          disp_val <= value;
          disp_dp  <= dp;
        end else if (pending) begin
          disp_val <= shadow_val;
          disp_dp  <= shadow_dp;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  logic [3:0]        nib [DIGITS];
  logic [DIGITS-1:0] blank;
  logic [7:0]        seg_p0;
  logic [DIGITS-1:0] an_p0;

  // Walk from the most significant digit down; a digit is blanked while every
  // nibble at and above it is zero. Digit 0 always shows.
  always_comb begin
    logic run_zero;
    run_zero = 1'b1;
    blank    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib[i]   = disp_val[4*i +: 4];
      run_zero = run_zero && (nib[i] == 4'h0);
      if ((BLANK_LEAD != 0) && (i > 0)) blank[i] = run_zero;
    end
  end

  always_comb begin
    seg_p0 = {disp_dp[idx], blank[idx] ? 7'h00 : decode7(nib[idx])};
    an_p0  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      an_p0[i] = guard_ok && (idx == IDX_W'(i));
    end
  end

  // ---- p1: output register with polarity applied ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_OFF;
      an  <= AN_OFF;
    end else begin
      seg <= seg_p0 ^ SEG_OFF;
      an  <= an_p0 ^ AN_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] value;
  logic [3:0]  dp;
  logic [7:0]  seg_a, seg_b, seg_c;
  logic [3:0]  an_a, an_b, an_c;
  logic        pend_a, pend_b, pend_c;

  int tests = 0;
  int fails = 0;
  int cyc_n = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [7:0] sa;   // expected seg with leading-zero blanking
    logic [7:0] sb;   // expected seg without blanking
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  // a: blanking on, active high; b: blanking off; c: blanking on, active low
  seg7_scan_driver #(.DIGITS(4), .DIV(4), .GUARD(1), .ACTIVE_LOW(0), .BLANK_LEAD(1)) dut_a (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp),
    .seg(seg_a), .an(an_a), .pending(pend_a));
  seg7_scan_driver #(.DIGITS(4), .DIV(4), .GUARD(1), .ACTIVE_LOW(0), .BLANK_LEAD(0)) dut_b (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp),
    .seg(seg_b), .an(an_b), .pending(pend_b));
  seg7_scan_driver #(.DIGITS(4), .DIV(4), .GUARD(1), .ACTIVE_LOW(1), .BLANK_LEAD(1)) dut_c (
    .clk(clk), .rst(rst), .load(load), .value(value), .dp(dp),
    .seg(seg_c), .an(an_c), .pending(pend_c));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s @cycle %0d: observed %02h expected %02h", tag, cyc_n, obs, exp);
    end
  endtask

  // Expected outputs for the first n edges of a frame: digit d, dwell pos p.
  task automatic push_frame(input int n,
                            input logic [7:0] a0, a1, a2, a3,
                            input logic [7:0] b0, b1, b2, b3);
    logic [7:0] sa [4];
    logic [7:0] sb [4];
    exp_t e;
    sa[0] = a0; sa[1] = a1; sa[2] = a2; sa[3] = a3;
    sb[0] = b0; sb[1] = b1; sb[2] = b2; sb[3] = b3;
    for (int k = 0; k < n; k++) begin
      e.an = ((k % 4) == 0) ? 4'h0 : (4'h1 << (k / 4));
      e.sa = sa[k / 4];
      e.sb = sb[k / 4];
      q.push_back(e);
    end
  endtask

  task automatic cyc();
    exp_t e;
    @(posedge clk);
    #1;
    cyc_n++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("an_a", {4'h0, an_a}, {4'h0, e.an});
      chk("seg_a", seg_a, e.sa);
      chk("an_b", {4'h0, an_b}, {4'h0, e.an});
      chk("seg_b", seg_b, e.sb);
      chk("an_c", {4'h0, an_c}, {4'h0, ~e.an});
      chk("seg_c", seg_c, ~e.sa);
    end
  endtask

  task automatic run(input int n);
    repeat (n) cyc();
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    load = 1'b1; value = v; dp = d;
    cyc();
    load = 1'b0; value = 16'h0; dp = 4'h0;
  endtask

  task automatic chk_reset_pins(input string tag);
    chk({tag, "_seg"},   seg_a, 8'h00);
    chk({tag, "_an"},    {4'h0, an_a}, 8'h00);
    chk({tag, "_pend"},  {7'h0, pend_a}, 8'h00);
    chk({tag, "_seg_b"}, seg_b, 8'h00);
    chk({tag, "_seg_c"}, seg_c, 8'hFF);
    chk({tag, "_an_c"},  {4'h0, an_c}, 8'h0F);
  endtask

  initial begin
    rst = 1'b1; load = 1'b0; value = 16'h0; dp = 4'h0;
    run(2);
    chk_reset_pins("rst");
    rst = 1'b0;
    cyc_n = 0;

    // ---- frame 0: cleared display; load 0x1234 mid-frame ----
    push_frame(16, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h3F);
    run(5);
    do_load(16'h1234, 4'b0100);
    chk("pend_after_load", {7'h0, pend_a}, 8'h01);
    run(9);
    chk("pend_before_fe", {7'h0, pend_a}, 8'h01);
    run(1);
    chk("pend_after_fe", {7'h0, pend_a}, 8'h00);

    // ---- frame 1: 0x1234 with dp on digit 2; load 0x0050 ----
    push_frame(16, 8'h66, 8'h4F, 8'hDB, 8'h06, 8'h66, 8'h4F, 8'hDB, 8'h06);
    run(3);
    do_load(16'h0050, 4'b0000);
    run(12);

    // ---- frame 2: 0x0050 blanked; load 0x0000 ----
    push_frame(16, 8'h3F, 8'h6D, 8'h00, 8'h00, 8'h3F, 8'h6D, 8'h3F, 8'h3F);
    run(2);
    do_load(16'h0000, 4'b0000);
    run(13);

    // ---- frame 3: all zero; load 0xAAAA then 0xBEEF (last wins) ----
    push_frame(16, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h3F);
    run(1);
    do_load(16'hAAAA, 4'b1111);
    chk("pend_first", {7'h0, pend_a}, 8'h01);
    run(5);
    do_load(16'hBEEF, 4'b0000);
    chk("pend_second", {7'h0, pend_a}, 8'h01);
    run(8);
    chk("pend_f3_end", {7'h0, pend_a}, 8'h00);

    // ---- frame 4: 0xBEEF; load 0x0007 on the frame_end cycle ----
    push_frame(16, 8'h71, 8'h79, 8'h79, 8'h7C, 8'h71, 8'h79, 8'h79, 8'h7C);
    run(15);
    chk("pend_pre_fe_load", {7'h0, pend_a}, 8'h00);
    do_load(16'h0007, 4'b0000);
    chk("pend_fe_load", {7'h0, pend_a}, 8'h00);

    // ---- frame 5: 0x0007 ----
    push_frame(16, 8'h07, 8'h00, 8'h00, 8'h00, 8'h07, 8'h3F, 8'h3F, 8'h3F);
    run(16);
    chk("pend_f5", {7'h0, pend_a}, 8'h00);

    // ---- frame 6: reset between edges while digit 2 is showing ----
    push_frame(10, 8'h07, 8'h00, 8'h00, 8'h00, 8'h07, 8'h3F, 8'h3F, 8'h3F);
    run(10);
    chk("an_before_rst", {4'h0, an_a}, 8'h04);
    #2;
    rst = 1'b1;
    #1;
    chk_reset_pins("midrst");
    chk("q_drained", 8'(q.size()), 8'h00);
    run(2);
    chk_reset_pins("midrst_hold");
    rst = 1'b0;
    cyc_n = 0;

    // ---- frame 7: scan restarts at digit 0 with a cleared display ----
    push_frame(16, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h3F, 8'h3F, 8'h3F);
    run(16);
    chk("q_empty_end", 8'(q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Safety net so the bench always ends on its own.
  initial begin
    #20000;
    $display("FAIL timeout: observed no finish, expected finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
